// File: rtl/curve25519_arbiter.sv
// curve25519_arbiter
// Shares a single curve25519 scalar-multiplier core between two requesters.
// Grants round-robin, latches the winner's operands, pulses core_start, waits
// for core_done under a watchdog and returns the result with a per-requester
// done pulse.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req{0,1}_valid/_n/_q    request level and operands (sampled on grant)
//   req{0,1}_grant          high from START through DONE for the owner
//   req{0,1}_done           1-cycle completion pulse for the owner
//   error                   valid with reqX_done; 1 = watchdog expired
//   result                  last good core output, held between operations
//   busy                    high in any state other than IDLE
//   core_start/_n/_q        start pulse and latched operands to the core
//   core_done/core_out      completion pulse and result from the core
module curve25519_arbiter #(
  parameter int unsigned KEY_SIZE      = 255,
  parameter int unsigned TIMEOUT_WIDTH = 22
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req1_valid,
  input  logic [KEY_SIZE-1:0] req0_n,
  input  logic [KEY_SIZE-1:0] req1_n,
  input  logic [KEY_SIZE-1:0] req0_q,
  input  logic [KEY_SIZE-1:0] req1_q,
  output logic                req0_grant,
  output logic                req1_grant,
  output logic                req0_done,
  output logic                req1_done,
  output logic                error,
  output logic [KEY_SIZE-1:0] result,
  output logic                busy,
  output logic                core_start,
  output logic [KEY_SIZE-1:0] core_n,
  output logic [KEY_SIZE-1:0] core_q,
  input  logic                core_done,
  input  logic [KEY_SIZE-1:0] core_out
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                   state;
  logic                     owner;
  logic                     last_owner;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     winner;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) begin
      winner = ~last_owner;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
      req0_grant <= 1'b0;
      req1_grant <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      error      <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_n     <= '0;
      core_q     <= '0;
    end else begin
      // Pulse outputs default low.
      core_start <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      case (state)
        StIdle: begin
          if (req0_valid || req1_valid) begin
            owner      <= winner;
            last_owner <= winner;
            core_n     <= winner ? req1_n : req0_n;
            core_q     <= winner ? req1_q : req0_q;
            req0_grant <= ~winner;
            req1_grant <= winner;
            busy       <= 1'b1;
            core_start <= 1'b1;
            state      <= StStart;
          end
        end
        StStart: begin
          wd_cnt <= '0;
          state  <= StWait;
        end
        StWait: begin
          wd_cnt <= wd_cnt + 1'b1;
          // core_done takes priority over a watchdog expiry in the same cycle.
          if (core_done) begin
            result    <= core_out;
            error     <= 1'b0;
            req0_done <= ~owner;
            req1_done <= owner;
            state     <= StDone;
          end else if (&wd_cnt) begin
            error     <= 1'b1;
            req0_done <= ~owner;
            req1_done <= owner;
            state     <= StDone;
          end
        end
        StDone: begin
          error      <= 1'b0;
          req0_grant <= 1'b0;
          req1_grant <= 1'b0;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_curve25519_arbiter.sv
// Self-checking bench for curve25519_arbiter with a stub core
// (latency stub_lat, core_out = n + q mod 2^255).
module tb_curve25519_arbiter;

  localparam int KS = 255;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [KS-1:0] req0_n, req1_n, req0_q, req1_q;
  logic          req0_grant, req1_grant, req0_done, req1_done;
  logic          error, busy, core_start, core_done;
  logic [KS-1:0] result, core_n, core_q, core_out;

  always #5 clock = ~clock;

  curve25519_arbiter #(
    .KEY_SIZE     (KS),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_n    (req0_n),
    .req1_n    (req1_n),
    .req0_q    (req0_q),
    .req1_q    (req1_q),
    .req0_grant(req0_grant),
    .req1_grant(req1_grant),
    .req0_done (req0_done),
    .req1_done (req1_done),
    .error     (error),
    .result    (result),
    .busy      (busy),
    .core_start(core_start),
    .core_n    (core_n),
    .core_q    (core_q),
    .core_done (core_done),
    .core_out  (core_out)
  );

  // Stub core: done pulse stub_lat cycles after the core_start cycle.
  int   stub_lat    = 10;
  bit   stub_mute   = 1'b0;
  bit   stub_active = 1'b0;
  int   stub_cnt    = 0;
  logic force_done  = 1'b0;

  always @(posedge clock) begin
    if (core_start) begin
      stub_active <= 1'b1;
      stub_cnt    <= stub_lat - 1;
    end else if (stub_active) begin
      if (stub_cnt == 0) stub_active <= 1'b0;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  assign core_done = (stub_active && (stub_cnt == 0) && !stub_mute) || force_done;
  assign core_out  = core_n + core_q;

  typedef struct {
    logic          owner;
    logic [KS-1:0] res;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [KS-1:0] res, input logic err);
    exp_t e;
    e.owner = owner;
    e.res   = res;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Waits for a done pulse, compares against the scoreboard head and drops
  // the owner's valid so the edge ending the done cycle sees it low.
  task automatic wait_done(input string tag, input int budget, output int cycles);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      seen = req0_done || req1_done;
    end
    check({tag, "_seen"}, 256'(seen), 256'(1));
    if (seen) begin
      check({tag, "_sb"}, 256'(sb.size() > 0), 256'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_who"}, 256'({req1_done, req0_done}), 256'(e.owner ? 2'b10 : 2'b01));
        check({tag, "_result"}, 256'(result), 256'(e.res));
        check({tag, "_error"}, 256'(error), 256'(e.err));
      end
      if (req0_done) req0_valid = 1'b0;
      if (req1_done) req1_valid = 1'b0;
    end
  endtask

  initial begin
    int c;
    bit any;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = '0; req0_q = '0; req1_n = '0; req1_q = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_ctrl", 256'({req0_grant, req1_grant, req0_done, req1_done, error, busy,
                              core_start}), 256'(0));
    check("reset_result", 256'(result), 256'(0));
    check("reset_core_nq", 256'(core_n | core_q), 256'(0));

    // Tie from reset: req0 wins first, then req1.
    req0_n = KS'(1); req0_q = KS'(9); req1_n = KS'(1); req1_q = KS'(5);
    req0_valid = 1'b1; req1_valid = 1'b1;
    push(1'b0, KS'(10), 1'b0);
    push(1'b1, KS'(6), 1'b0);
    wait_done("tie1_a", 40, c);
    wait_done("tie1_b", 40, c);
    @(negedge clock);

    // Single request with operand change after grant.
    req0_n = KS'(3); req0_q = KS'(9); req0_valid = 1'b1;
    push(1'b0, KS'(12), 1'b0);
    @(negedge clock);
    check("single_start", 256'({core_start, req0_grant, req1_grant, busy}), 256'(4'b1101));
    check("single_core_q", 256'(core_q), 256'(9));
    req0_q = '0;
    @(negedge clock);
    check("single_start_pulse", 256'(core_start), 256'(0));
    wait_done("single", 40, c);
    check("single_latency", 256'(c + 2), 256'(12));
    @(negedge clock);
    check("single_idle", 256'({busy, req0_grant, req0_done, req1_done}), 256'(0));
    check("single_hold", 256'(result), 256'(12));

    // Tie after req0 was served last: req1 goes first.
    req0_n = KS'(2); req0_q = KS'(7); req1_n = KS'(4); req1_q = KS'(4);
    req0_valid = 1'b1; req1_valid = 1'b1;
    push(1'b1, KS'(8), 1'b0);
    push(1'b0, KS'(9), 1'b0);
    wait_done("tie2_a", 40, c);
    wait_done("tie2_b", 40, c);
    @(negedge clock);

    // Watchdog: core never answers, result keeps 9.
    stub_mute = 1'b1;
    req0_n = KS'(5); req0_q = KS'(5); req0_valid = 1'b1;
    push(1'b0, KS'(9), 1'b1);
    @(negedge clock);
    check("wd_start", 256'(core_start), 256'(1));
    wait_done("wd", 40, c);
    check("wd_latency", 256'(c), 256'(17));
    @(negedge clock);
    force_done = 1'b1;   // late pulse while idle
    @(negedge clock);
    force_done = 1'b0;
    check("late_done_idle", 256'({busy, req0_done, req1_done, error, core_start}), 256'(0));
    @(negedge clock);
    check("late_done_hold", 256'(result), 256'(9));
    stub_mute = 1'b0;

    // Done in the same cycle the watchdog counter is all-ones.
    stub_lat = 16;
    req1_n = KS'(1); req1_q = KS'(2); req1_valid = 1'b1;
    push(1'b1, KS'(3), 1'b0);
    @(negedge clock);
    check("coll_start", 256'({core_start, req1_grant}), 256'(2'b11));
    wait_done("coll", 40, c);
    check("coll_latency", 256'(c), 256'(17));
    stub_lat = 10;
    @(negedge clock);

    // Reset while waiting on the core; stale done must be ignored.
    req0_n = KS'(10); req0_q = KS'(20); req0_valid = 1'b1;
    @(negedge clock);
    check("rst_start", 256'(core_start), 256'(1));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req0_valid = 1'b0;
    check("midrst_ctrl", 256'({req0_grant, req1_grant, req0_done, req1_done, error, busy,
                               core_start}), 256'(0));
    check("midrst_result", 256'(result), 256'(0));
    check("midrst_core_nq", 256'(core_n | core_q), 256'(0));
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (req0_done || req1_done || busy) any = 1'b1;
    end
    check("stale_done_ignored", 256'(any), 256'(0));
    check("stale_result", 256'(result), 256'(0));
    req1_n = KS'(7); req1_q = KS'(8); req1_valid = 1'b1;
    push(1'b1, KS'(15), 1'b0);
    wait_done("post_rst", 40, c);
    check("post_rst_latency", 256'(c), 256'(12));
    check("sb_empty", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
